// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard front end:
// frame FSM states, set-2 scancodes and the key index used for held bits.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESCAPE = 8'h76;
  localparam logic [7:0] SC_PAUSE  = 8'h4D;
  localparam logic [7:0] SC_RESET  = 8'h2D;
  localparam logic [7:0] SC_PLUS   = 8'h79;
  localparam logic [7:0] SC_MINUS  = 8'h7B;

  typedef enum logic [3:0] {
    K_UP, K_DOWN, K_LEFT, K_RIGHT,
    K_ENTER, K_ESCAPE, K_PAUSE, K_RESET, K_PLUS, K_MINUS
  } key_idx_t;

  localparam int NUM_KEYS = 10;

  // One-hot key vector for a code; the extended flag must match the key exactly.
  function automatic logic [NUM_KEYS-1:0] key_match(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m[K_UP]    = 1'b1;
        SC_DOWN:  m[K_DOWN]  = 1'b1;
        SC_LEFT:  m[K_LEFT]  = 1'b1;
        SC_RIGHT: m[K_RIGHT] = 1'b1;
        default:  ;
      endcase
    end else begin
      case (code)
        SC_ENTER:  m[K_ENTER]  = 1'b1;
        SC_ESCAPE: m[K_ESCAPE] = 1'b1;
        SC_PAUSE:  m[K_PAUSE]  = 1'b1;
        SC_RESET:  m[K_RESET]  = 1'b1;
        SC_PLUS:   m[K_PLUS]   = 1'b1;
        SC_MINUS:  m[K_MINUS]  = 1'b1;
        default:   ;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame
// FSM with odd-parity/stop checking and an inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES);

  logic           r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;
  logic           r_clk_filt;
  logic [FCW-1:0] r_filt_cnt;
  logic           w_filt_flip, w_fall;

  frame_state_t   r_state, w_next_state;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic           r_parity;
  logic [TOW-1:0] r_to_cnt;
  logic           w_good, w_bad, w_timeout;
  logic           r_byte_valid, r_frame_err;
  logic [7:0]     r_byte_data;

  // NOTE: synchronizer and filter reset to 1 so leaving reset looks like an idle bus, not an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1  <= i_ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_data_s1 <= i_ps2_data;
      r_data_s2 <= r_data_s1;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (w_filt_flip) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_filt_flip = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  assign w_fall      = w_filt_flip && r_clk_filt;

  // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    w_timeout    = (r_state != IDLE) && !w_fall && (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));
    case (r_state)
      IDLE:    if (w_fall && !r_data_s2) w_next_state = DATA;
      DATA:    if (w_fall && r_bit_cnt == 3'd7) w_next_state = PARITY;
      PARITY:  if (w_fall) w_next_state = STOP;
      STOP: begin
        if (w_fall) begin
          w_next_state = IDLE;
          if (r_data_s2 && (^{r_shift, r_parity})) w_good = 1'b1;
          else                                     w_bad  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (w_timeout) w_next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_data  <= '0;
    end else begin
      r_byte_valid <= w_good;
      r_frame_err  <= w_bad | w_timeout;
      if (w_good) r_byte_data <= r_shift;
      if (r_state == IDLE || w_fall) r_to_cnt <= '0;
      else                           r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          IDLE:    r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {r_data_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY:  r_parity <= r_data_s2;
          default: ;
        endcase
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_byte_data  = r_byte_data;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game-control decoder: E0/F0 prefix tracking, key matching,
// held levels for arrows and press pulses for the command keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       escape,
  output logic       pause,
  output logic       reset,
  output logic       plus,
  output logic       minus,
  output logic       frame_err,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic                w_byte_valid, w_frame_err;
  logic [7:0]          w_byte_data;
  logic [NUM_KEYS-1:0] w_match;
  logic                r_ext, r_brk;
  logic [NUM_KEYS-1:0] r_held, r_pulse;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_data  (PS2_DATA),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_frame_err)
  );

  assign w_match = key_match(r_ext, w_byte_data);

  // Pulses fire only on a held 0->1 edge, so typematic repeats stay silent.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_held  <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (w_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte_data == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte_data == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_brk) begin
            r_held <= r_held & ~w_match;
          end else begin
            r_held  <= r_held | w_match;
            r_pulse <= w_match & ~r_held;
          end
        end
      end
    end
  end

  assign up         = r_held[K_UP];
  assign down       = r_held[K_DOWN];
  assign left       = r_held[K_LEFT];
  assign right      = r_held[K_RIGHT];
  assign enter      = r_pulse[K_ENTER];
  assign escape     = r_pulse[K_ESCAPE];
  assign pause      = r_pulse[K_PAUSE];
  assign reset      = r_pulse[K_RESET];
  assign plus       = r_pulse[K_PLUS];
  assign minus      = r_pulse[K_MINUS];
  assign frame_err  = w_frame_err;
  assign byte_valid = w_byte_valid;
  assign byte_data  = w_byte_data;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames on the pins, predicts bytes and
// key outputs from a scancode-level model, and compares every cycle.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk, ps2_data;
  logic       up, down, left, right, enter, escape, pause, reset_o, plus, minus;
  logic       frame_err, byte_valid;
  logic [7:0] byte_data;

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(25000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_data),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .enter     (enter),
    .escape    (escape),
    .pause     (pause),
    .reset     (reset_o),
    .plus      (plus),
    .minus     (minus),
    .frame_err (frame_err),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected receiver events in order; the driver pushes, the compare process pops.
  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Key table, index 0..3 = arrows (levels), 4..9 = pulse keys.
  typedef struct {
    bit         ext;
    logic [7:0] code;
  } key_t;
  key_t keymap[10] = '{
    '{1'b1, 8'h75}, '{1'b1, 8'h72}, '{1'b1, 8'h6B}, '{1'b1, 8'h74},
    '{1'b0, 8'h5A}, '{1'b0, 8'h76}, '{1'b0, 8'h4D}, '{1'b0, 8'h2D},
    '{1'b0, 8'h79}, '{1'b0, 8'h7B}};

  bit         m_ext, m_brk;
  bit         m_held[10];
  bit         m_pulse[10];
  logic [7:0] m_last;
  int         pc[10];
  int         bv_cnt = 0, fe_cnt = 0;
  logic       rst_at_edge = 1'b1;

  wire [9:0] dut_keys = {minus, plus, reset_o, pause, escape, enter, right, left, down, up};

  task automatic model_clear();
    m_ext = 0;
    m_brk = 0;
    for (int i = 0; i < 10; i++) begin
      m_held[i]  = 0;
      m_pulse[i] = 0;
    end
    m_last = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    k = -1;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      for (int i = 0; i < 10; i++)
        if (keymap[i].code == b && keymap[i].ext == m_ext) k = i;
      if (k >= 0) begin
        if (m_brk) m_held[k] = 0;
        else begin
          if (!m_held[k]) m_pulse[k] = 1;
          m_held[k] = 1;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  always @(posedge clk) rst_at_edge <= !reset_n;

  always @(negedge clk) begin : cmp
    logic [9:0] exp_keys;
    exp_t       e;
    if (rst_at_edge) begin
      check("reset_outputs", {12'h0, dut_keys, frame_err, byte_valid, byte_data}, 32'h0);
      model_clear();
      exp_q.delete();
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp_keys[i] = (i < 4) ? m_held[i] : m_pulse[i];
        m_pulse[i]  = 0;
        pc[i] += int'(dut_keys[i]);
      end
      check("keys", {22'h0, dut_keys}, {22'h0, exp_keys});
      check("bv_fe_exclusive", {31'h0, byte_valid & frame_err}, 32'h0);
      bv_cnt += int'(byte_valid);
      fe_cnt += int'(frame_err);
      if (byte_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {22'h0, byte_valid, frame_err, byte_data}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {31'h0, frame_err}, {31'h0, e.err});
          if (!e.err) begin
            check("byte_data", {24'h0, byte_data}, {24'h0, e.data});
            m_last = e.data;
            model_byte(e.data);
          end else begin
            m_ext = 0;
            m_brk = 0;
          end
        end
      end else begin
        check("byte_data_held", {24'h0, byte_data}, {24'h0, m_last});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device-side frame: data changes while clock is high, host samples on the fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int half, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clk = 1'b0;
      tick(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] b, input int half = 40);
    exp_q.push_back('{err: 1'b0, data: b});
    send_frame(b, 1'b0, half, 11);
    tick(20);
  endtask

  int b_bv, b_fe, b_pc[10];

  task automatic snap();
    b_bv = bv_cnt;
    b_fe = fe_cnt;
    for (int i = 0; i < 10; i++) b_pc[i] = pc[i];
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    reset_n = 1'b1;
    tick(20);

    // Single press of Enter: first frame at 12.5 kHz, make and break.
    snap();
    good(8'h5A, 1000);
    good(8'hF0);
    good(8'h5A);
    check("single_bv_count", bv_cnt - b_bv, 3);
    check("single_enter_count", pc[4] - b_pc[4], 1);
    check("single_fe_count", fe_cnt - b_fe, 0);

    // Extended hold with typematic repeats.
    good(8'hE0);
    good(8'h75);
    check("up_after_make", {31'h0, up}, 1);
    repeat (5) good(8'h75);
    check("up_through_repeats", {31'h0, up}, 1);
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    check("up_after_break", {31'h0, up}, 0);
    good(8'h75);
    check("keypad8_not_up", {31'h0, up}, 0);

    // Remaining arrows: press, check level, release.
    good(8'hE0); good(8'h6B);
    good(8'hE0); good(8'h72);
    good(8'hE0); good(8'h74);
    check("arrows_held", {28'h0, right, left, down, up}, 32'hE);
    good(8'hE0); good(8'hF0); good(8'h72);
    check("down_released", {28'h0, right, left, down, up}, 32'hC);

    // Parity error, then a good frame of the same key.
    snap();
    exp_q.push_back('{err: 1'b1, data: 8'h00});
    send_frame(8'h2D, 1'b1, 40, 11);
    tick(20);
    check("parity_fe_count", fe_cnt - b_fe, 1);
    check("parity_bv_count", bv_cnt - b_bv, 0);
    check("parity_reset_count", pc[7] - b_pc[7], 0);
    good(8'h2D);
    check("after_parity_reset_count", pc[7] - b_pc[7], 1);
    good(8'hF0); good(8'h2D);

    // Timeout after start bit + 3 data bits, then a clean frame.
    snap();
    exp_q.push_back('{err: 1'b1, data: 8'h00});
    send_frame(8'h4D, 1'b0, 40, 4);
    tick(26000);
    check("timeout_fe_count", fe_cnt - b_fe, 1);
    good(8'h4D);
    check("after_timeout_pause_count", pc[6] - b_pc[6], 1);
    check("after_timeout_byte", {24'h0, byte_data}, 32'h4D);
    good(8'hF0); good(8'h4D);

    // 2-cycle clock glitch with data low must not look like a start bit.
    snap();
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(2);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(20);
    check("glitch_no_bv", bv_cnt - b_bv, 0);
    check("glitch_no_fe", fe_cnt - b_fe, 0);
    good(8'h79);
    check("plus_count", pc[8] - b_pc[8], 1);
    good(8'h79);
    check("plus_repeat_count", pc[8] - b_pc[8], 1);
    good(8'hF0); good(8'h79);
    good(8'h7B);
    check("minus_count", pc[9] - b_pc[9], 1);

    // Reset after the 5th data bit of 76 while up and left are held.
    good(8'hE0); good(8'h75);
    check("up_before_reset", {31'h0, up}, 1);
    send_frame(8'h76, 1'b0, 40, 6);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("rst_mid_outputs", {12'h0, dut_keys, frame_err, byte_valid, byte_data}, 32'h0);
    tick(40);
    snap();
    good(8'h76);
    check("escape_after_reset", pc[5] - b_pc[5], 1);
    check("escape_byte", {24'h0, byte_data}, 32'h76);

    tick(100);
    check("all_events_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames on `PS2_CLK`/`PS2_DATA`, checks each frame, and turns the scancode stream (set 2, with `E0` extended and `F0` break prefixes) into game-control signals. It sits between the board PS/2 pins and the game logic. Arrow keys come out as held levels for player movement. Enter, Escape, P, R and keypad +/− come out as single-cycle press pulses for the game-state machine and the radius control. It runs on the divided 25 MHz pixel clock.

## Interface
- `FILTER_LEN`, 4: number of consecutive equal samples of synchronized `PS2_CLK` required before a level change is accepted.
- `TIMEOUT_CYCLES`, 25000: idle cycles allowed between falling edges within one frame (1 ms at 25 MHz).
- `clk` input 1: divided system clock (`clk_d` domain).
- `reset_n` input 1: synchronous, active-low reset.
- `PS2_CLK` input 1: raw PS/2 clock pin, asynchronous.
- `PS2_DATA` input 1: raw PS/2 data pin, asynchronous.
- `up`, `down`, `left`, `right` output 1 each: held levels for the arrow keys.
- `enter`, `escape`, `pause`, `reset`, `plus`, `minus` output 1 each: one-cycle press pulses.
- `frame_err` output 1: one-cycle pulse on a parity error, a stop-bit error or a timeout.
- `byte_valid` output 1: one-cycle pulse when a good byte is received.
- `byte_data` output 8: last good byte, held between pulses.

## Operation
- **Input conditioning.**
  - `PS2_CLK` and `PS2_DATA` each pass through a 2-FF synchronizer.
  - Clock filter: the filtered level changes only after `FILTER_LEN` consecutive equal samples.
  - A falling edge of the filtered clock is a sample event. Data is sampled from synchronized `PS2_DATA` on that event.
- **Frame FSM.**
  - IDLE: an event with data 0 (start bit) → DATA, bit count = 0. An event with data 1 is ignored.
  - DATA: shift in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if data = 1 and odd parity holds over the 8 data bits plus the parity bit → good byte. Otherwise → `frame_err`. Both paths return to IDLE.
  - Timeout: in any non-IDLE state, a cycle counter clears on each event. Reaching `TIMEOUT_CYCLES` → `frame_err` and go to IDLE.
- **Decoder, per good byte.**
  - `E0` sets the `ext` flag. `F0` sets the `brk` flag. Neither produces an output.
  - Any other byte is matched together with `ext`, then both flags clear.
  - On `frame_err` both flags also clear.
- **Key map** (codes listed in the package):
  - `up` = E0 75, `down` = E0 72, `left` = E0 6B, `right` = E0 74.
  - `enter` = 5A, `escape` = 76, `pause` = 4D, `reset` = 2D, `plus` = 79, `minus` = 7B (all non-extended).
- **Held state.** Each mapped key has a held bit: set on make, cleared on break.
  - A pulse fires only on a held 0→1 transition, so typematic repeats produce no extra pulses.
  - An `ext` mismatch means no match. Example: non-extended 75 (keypad 8) does not affect `up`.
- **Ignored inputs.** Unmapped codes, and breaks for keys not held, have no effect.

## Timing
- **Reset.** While `reset_n` = 0 at a `clk` edge:
  - All outputs are 0, `byte_data` = 00.
  - FSM = IDLE, flags, held bits and counters cleared.
  - Synchronizer and filter registers are forced to 1 (idle bus).
  - Reset in the middle of a frame drops the partial frame. The next start bit after reset is received normally.
- **Stop-bit event to outputs.**
  - `byte_valid`/`frame_err` assert 1 cycle after the cycle in which the stop-bit event is detected.
  - Key levels and pulses update 1 cycle after `byte_valid`.
- **Pin to event latency:** 2 sync cycles + `FILTER_LEN` cycles from the pin edge to the event.
- **Mutual exclusion:** `byte_valid` and `frame_err` never assert in the same cycle.
- **Timeout at the same time as an event:** the event wins and the counter clears.
- **Outputs are registered.** No combinational path from the pins to any output.

## Structure
- Package `ps2_pkg` holds:
  - the frame FSM state enum (IDLE, DATA, PARITY, STOP);
  - the scancode constants `SC_EXT`=E0, `SC_BRK`=F0 and the ten key codes;
  - the key-index enum used for the held vector.
- Sub-module `ps2_frame_rx`: synchronizers, filter, frame FSM and timeout. It outputs `byte_valid`, `byte_data` and `frame_err`.
- The top level adds the prefix flags, key matching, held bits and pulse generation.

## Test plan
- **Single press.** Frames 5A, F0 5A at 12.5 kHz PS/2 clock → `byte_valid` ×3, `enter` pulses exactly once for 1 cycle. `frame_err` stays 0.
- **Extended hold.** E0 75, then 75 repeated 5×, then E0 F0 75 → `up` rises after the second byte, stays 1 through the repeats, falls after the final 75. Non-extended 75 alone leaves `up` = 0.
- **Parity error.** Frame for 2D with the parity bit inverted → `frame_err` pulse, no `byte_valid`, `reset` stays 0. The next good 2D → `reset` pulse.
- **Timeout.** Start bit + 3 data bits, then the clock idles for 25001 cycles → one `frame_err`, FSM back to IDLE. A following 4D frame → `pause` pulse.
- **Glitch rejection.** A 2-cycle low glitch on `PS2_CLK` with `FILTER_LEN` = 4 → no event, no outputs.
- **Reset mid-frame.** `reset_n` = 0 for 1 cycle after the 5th data bit of 76 → all outputs 0. Subsequent 76 → `escape` pulse.
